// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Filters a raw PLL lock and releases NUM_CH reset domains in
//               turn, STAGE_DELAY cycles apart, tearing everything down again
//               on lock loss. Macro PLL_RESET_LOSS_COUNTER_EN builds the
//               saturating lock-loss counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
    parameter int NUM_CH      = 2,
    parameter int LOCK_FILTER = 1024,
    parameter int STAGE_DELAY = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              clear_lock_lost,
    output logic [NUM_CH-1:0] reset_out,
    output logic              sdram_clk_en,
    output logic              ready,
    output logic              lock_lost,
    output logic [7:0]        lock_loss_count
);

    localparam int c_FILT_W  = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int c_STAGE_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int c_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [c_FILT_W-1:0]  c_FILT_LAST  = c_FILT_W'(LOCK_FILTER - 1);
    localparam logic [c_STAGE_W-1:0] c_STAGE_LAST = c_STAGE_W'(STAGE_DELAY - 1);
    localparam logic [c_CH_W-1:0]    c_CH_LAST    = c_CH_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0]    c_CH_ONE     = NUM_CH'(1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_FILTER    = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic                 r_lock_meta;
    logic                 r_lock_sync;
    state_t               r_state;
    logic [c_FILT_W-1:0]  r_filt_cnt;
    logic [c_STAGE_W-1:0] r_stage_cnt;
    logic [c_CH_W-1:0]    r_ch_idx;
    logic [NUM_CH-1:0]    r_reset_out;
    logic                 r_sdram_en;
    logic                 r_ready;
    logic                 r_lock_lost;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [c_FILT_W-1:0]  w_filt_cnt_nxt;
    logic [c_STAGE_W-1:0] w_stage_cnt_nxt;
    logic [c_CH_W-1:0]    w_ch_idx_nxt;
    logic [NUM_CH-1:0]    w_reset_out_nxt;
    logic                 w_sdram_en_nxt;
    logic                 w_ready_nxt;
    logic                 w_lock_lost_nxt;
    logic                 w_loss;
    logic                 w_loss_run;

    // Two-flop synchroniser; nothing downstream ever looks at pll_lock itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_WAIT_LOCK;
            r_filt_cnt  <= '0;
            r_stage_cnt <= '0;
            r_ch_idx    <= '0;
            r_reset_out <= '1;
            r_sdram_en  <= 1'b0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_filt_cnt  <= w_filt_cnt_nxt;
            r_stage_cnt <= w_stage_cnt_nxt;
            r_ch_idx    <= w_ch_idx_nxt;
            r_reset_out <= w_reset_out_nxt;
            r_sdram_en  <= w_sdram_en_nxt;
            r_ready     <= w_ready_nxt;
            r_lock_lost <= w_lock_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_filt_cnt_nxt  = r_filt_cnt;
        w_stage_cnt_nxt = r_stage_cnt;
        w_ch_idx_nxt    = r_ch_idx;
        w_reset_out_nxt = r_reset_out;
        w_sdram_en_nxt  = r_sdram_en;
        w_ready_nxt     = r_ready;
        w_loss          = 1'b0;
        w_loss_run      = 1'b0;

        case (r_state)
            S_WAIT_LOCK: begin
                if (r_lock_sync) begin
                    w_state_nxt    = S_FILTER;
                    w_filt_cnt_nxt = '0;
                end
            end

            S_FILTER: begin
                if (!r_lock_sync) begin
                    w_loss = 1'b1;
                end else if (r_filt_cnt == c_FILT_LAST) begin
                    w_state_nxt     = S_RELEASE;
                    w_stage_cnt_nxt = '0;
                    w_ch_idx_nxt    = '0;
                    w_sdram_en_nxt  = 1'b1;
                end else begin
                    w_filt_cnt_nxt = r_filt_cnt + c_FILT_W'(1);
                end
            end

            S_RELEASE: begin
                if (!r_lock_sync) begin
                    w_loss = 1'b1;
                end else if (r_stage_cnt == c_STAGE_LAST) begin
                    // One channel per completed stage; the last one also
                    // lands in RUN so ready rises with the final release.
                    w_stage_cnt_nxt = '0;
                    w_reset_out_nxt = r_reset_out & ~(c_CH_ONE << r_ch_idx);
                    if (r_ch_idx == c_CH_LAST) begin
                        w_state_nxt = S_RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_ch_idx_nxt = r_ch_idx + c_CH_W'(1);
                    end
                end else begin
                    w_stage_cnt_nxt = r_stage_cnt + c_STAGE_W'(1);
                end
            end

            S_RUN: begin
                if (!r_lock_sync) begin
                    w_loss     = 1'b1;
                    w_loss_run = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_WAIT_LOCK;
            end
        endcase

        if (w_loss) begin
            w_state_nxt     = S_WAIT_LOCK;
            w_filt_cnt_nxt  = '0;
            w_stage_cnt_nxt = '0;
            w_ch_idx_nxt    = '0;
            w_reset_out_nxt = '1;
            w_sdram_en_nxt  = 1'b0;
            w_ready_nxt     = 1'b0;
        end

        // Set has priority over a coincident clear.
        if (w_loss_run) begin
            w_lock_lost_nxt = 1'b1;
        end else if (clear_lock_lost) begin
            w_lock_lost_nxt = 1'b0;
        end else begin
            w_lock_lost_nxt = r_lock_lost;
        end
    end

`ifdef PLL_RESET_LOSS_COUNTER_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_loss_cnt <= 8'd0;
        end else if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`else
    assign lock_loss_count = 8'd0;
`endif

    assign reset_out    = r_reset_out;
    assign sdram_clk_en = r_sdram_en;
    assign ready        = r_ready;
    assign lock_lost    = r_lock_lost;

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL provide parameter NUM_CH, default 2, number of sequenced reset outputs (>=1).
REQ-002 SHALL provide parameter LOCK_FILTER, default 1024, consecutive locked cycles required before release (>=1).
REQ-003 SHALL provide parameter STAGE_DELAY, default 16, cycles between successive channel releases (>=1).
REQ-004 SHALL provide port clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-high block reset.
REQ-006 SHALL provide port pll_lock  input  1  raw PLL lock, asynchronous to clk.
REQ-007 SHALL provide port clear_lock_lost  input  1  single-cycle clear of the sticky lock_lost flag.
REQ-008 SHALL provide port reset_out  output  NUM_CH  per-domain active-high resets.
REQ-009 SHALL provide port sdram_clk_en  output  1  enable for the SDRAM clock DDR output data.
REQ-010 SHALL provide port ready  output  1  high while all channels are released.
REQ-011 SHALL provide port lock_lost  output  1  sticky: lock dropped while in RUN.
REQ-012 SHALL provide port lock_loss_count  output  8  saturating count of lock losses.

Function
REQ-013 SHALL synchronise pll_lock through two flops; lock_sync (second flop) is the only lock value used internally.
REQ-014 SHALL implement states WAIT_LOCK, FILTER, RELEASE, RUN; all outputs registered.
REQ-015 WAIT_LOCK: lock_sync=1 -> FILTER with filter counter cleared; otherwise stay.
REQ-016 FILTER: SHALL last exactly LOCK_FILTER cycles of continuous lock_sync=1, then -> RELEASE with stage counter cleared.
REQ-017 RELEASE: reset_out[i] SHALL deassert exactly STAGE_DELAY*(i+1) cycles after RELEASE entry, index 0 first.
REQ-018 RELEASE: on the cycle reset_out[NUM_CH-1] deasserts, state -> RUN and ready SHALL assert in that same cycle.
REQ-019 sdram_clk_en SHALL be 1 in RELEASE and RUN, 0 in WAIT_LOCK and FILTER.
REQ-020 lock_sync=0 in FILTER, RELEASE or RUN SHALL, at the next edge, enter WAIT_LOCK with all reset_out=1, ready=0, sdram_clk_en=0.
REQ-021 Lock loss from FILTER, RELEASE or RUN SHALL increment lock_loss_count, saturating at 255.
REQ-022 Lock loss from RUN only SHALL set lock_lost; clear_lock_lost=1 clears it; simultaneous set and clear -> set wins.
REQ-023 Lock glitch of fewer than LOCK_FILTER cycles SHALL restart filtering from zero; partial counts are never retained.
REQ-024 Counters SHALL be sized $clog2 of their terminal value (min 1 bit); no wrap-around in any state.

Reset
REQ-025 reset=1 at an edge SHALL force: state WAIT_LOCK, sync flops 0, reset_out all 1, sdram_clk_en 0, ready 0, lock_lost 0, lock_loss_count 0.
REQ-026 reset mid-operation (any state) SHALL behave identically to REQ-025; it SHALL NOT count as a lock loss.
REQ-027 After reset deasserts, a lock already high SHALL be treated as a fresh rise (sync pipeline refills).

Configuration
REQ-028 Macro PLL_RESET_LOSS_COUNTER_EN defined: lock_loss_count behaves per REQ-021.
REQ-029 Macro PLL_RESET_LOSS_COUNTER_EN undefined: lock_loss_count tied to 0 and no counter logic is built; lock_lost unaffected.

Verification (NUM_CH=3, LOCK_FILTER=8, STAGE_DELAY=4)
REQ-030 pll_lock rises at cycle 0, held -> reset_out[0] falls at cycle 15, [1] at 19, [2] and ready at 23; sdram_clk_en rises at 11.
REQ-031 pll_lock high, then low for 1 cycle during FILTER -> state returns to WAIT_LOCK, full 8-cycle filter restarts, lock_loss_count=1, lock_lost=0.
REQ-032 In RUN, pll_lock drops -> 3 cycles later all reset_out=1, ready=0, sdram_clk_en=0, lock_lost=1; clear_lock_lost pulse -> lock_lost=0.
REQ-033 300 lock losses from RUN -> lock_loss_count=255; with macro undefined -> lock_loss_count stays 0.
REQ-034 reset pulsed during RELEASE after reset_out[0] released -> next cycle all reset_out=1, counters 0, lock_loss_count unchanged at 0.
REQ-035 Loss coinciding with clear_lock_lost in RUN -> lock_lost=1.
